// File: rtl/mem_arbiter_pkg.sv
// Shared core package: ALU op codes, memory arbiter FSM encoding and default widths.
// Imported by the core blocks so encodings stay consistent across the pipeline.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    return (limit < 32'd1) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; a saturating starve counter guarantees fetch progress.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_valid_o,
  input  logic                    d_read_i,
  input  logic                    d_write_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_valid_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    stall_o
);

  localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_r;
  arb_state_t       state_next_s;
  logic [CNT_W-1:0] starve_r;
  logic [CNT_W-1:0] starve_next_s;
  logic             d_req_s;
  logic             grant_open_s;
  logic             fetch_wins_s;
  logic             grant_if_s;
  logic             grant_d_s;
  logic             ack_s;

  // Arbitration decision and FSM next state; no grant while a valid pulse is out
  always_comb begin
    d_req_s      = d_read_i | d_write_i;
    fetch_wins_s = if_req_i & (~d_req_s | (starve_r == STARVE_MAX));
    grant_open_s = 1'b0;
    grant_if_s   = 1'b0;
    grant_d_s    = 1'b0;
    ack_s        = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        grant_open_s = ~rst & ~if_valid_o & ~d_valid_o;
        if (grant_open_s && fetch_wins_s) begin
          grant_if_s   = 1'b1;
          state_next_s = BUSY_IF;
        end else if (grant_open_s && d_req_s) begin
          grant_d_s    = 1'b1;
          state_next_s = BUSY_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        ack_s = mem_ack_i;
        if (mem_ack_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Starve counter: counts data grants that bypassed a waiting fetch
  always_comb begin
    starve_next_s = starve_r;
    if (grant_if_s) begin
      starve_next_s = {CNT_W{1'b0}};
    end else if (grant_d_s) begin
      if (!if_req_i) begin
        starve_next_s = {CNT_W{1'b0}};
      end else if (starve_r == STARVE_MAX) begin
        starve_next_s = starve_r;
      end else begin
        starve_next_s = starve_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      starve_next_s = starve_r;
    end
  end

  // FSM state and starve counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      starve_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      starve_r <= starve_next_s;
    end
  end

  // Memory request fields held from grant to ack; completion data and valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_o <= {DATA_WIDTH{1'b0}};
      mem_be_o    <= {BE_W{1'b0}};
      if_rdata_o  <= {DATA_WIDTH{1'b0}};
      d_rdata_o   <= {DATA_WIDTH{1'b0}};
      if_valid_o  <= 1'b0;
      d_valid_o   <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      d_valid_o  <= 1'b0;
      if (grant_if_s) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= {DATA_WIDTH{1'b0}};
        mem_be_o    <= {BE_W{1'b1}};
      end else if (grant_d_s) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= d_write_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        mem_be_o    <= d_be_i;
      end else if (ack_s) begin
        mem_req_o <= 1'b0;
        if (state_r == BUSY_IF) begin
          if_rdata_o <= mem_rdata_i;
          if_valid_o <= 1'b1;
        end else begin
          d_valid_o <= 1'b1;
          if (!mem_we_o) begin
            d_rdata_o <= mem_rdata_i;
          end
        end
      end
    end
  end

  assign if_gnt_o = grant_if_s;
  assign stall_o  = (if_req_i & ~if_valid_o) | ((d_read_i | d_write_i) & ~d_valid_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: latency-programmable memory model,
// scoreboard queues for memory requests and completions, one task per scenario.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        d_read_i;
  logic        d_write_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  mem_exp_t    exp_mem_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  mem_exp_t    mon_e;
  logic [31:0] mon_d;
  logic        req_q = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  int          mem_lat = 2;
  bit          mem_auto = 1'b1;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  // memory model: ack one cycle, mem_lat cycles after mem_req_o rises
  always begin
    @(posedge clk); #1;
    if (mem_auto) begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        wait_cnt  = 0;
      end else if (mem_req_o) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_data(mem_addr_o);
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // scoreboard consumer: memory requests and completions
  always @(negedge clk) begin
    if (mem_req_o && !req_q) begin
      n_total++;
      if (exp_mem_q.size() == 0) begin
        $display("FAIL mem_req_unexpected: got addr %h, no request predicted", mem_addr_o);
      end else begin
        mon_e = exp_mem_q.pop_front();
        if ({mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o} !== mon_e)
          $display("FAIL mem_req_fields: got %h/%b/%h/%b expected %h/%b/%h/%b",
                   mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
                   mon_e.addr, mon_e.we, mon_e.wdata, mon_e.be);
        else n_pass++;
      end
    end
    req_q = mem_req_o;
    if (if_valid_o) begin
      n_total++;
      if (exp_if_q.size() == 0) begin
        $display("FAIL if_valid_unexpected: got rdata %h, none predicted", if_rdata_o);
      end else begin
        mon_d = exp_if_q.pop_front();
        if (if_rdata_o !== mon_d) $display("FAIL if_rdata: got %h expected %h", if_rdata_o, mon_d);
        else n_pass++;
      end
    end
    if (d_valid_o) begin
      n_total++;
      if (exp_d_q.size() == 0) begin
        $display("FAIL d_valid_unexpected: got rdata %h, none predicted", d_rdata_o);
      end else begin
        mon_d = exp_d_q.pop_front();
        if (d_rdata_o !== mon_d) $display("FAIL d_rdata: got %h expected %h", d_rdata_o, mon_d);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 70'd0)
      $display("FAIL reset_mem_fields: got %b/%b/%h/%h/%b expected all zero",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
    else n_pass++;
    n_total++;
    if ({if_rdata_o, d_rdata_o, if_valid_o, d_valid_o} !== 66'd0)
      $display("FAIL reset_outputs: got %h/%h/%b/%b expected all zero",
               if_rdata_o, d_rdata_o, if_valid_o, d_valid_o);
    else n_pass++;
    n_total++;
    if (if_gnt_o !== 1'b0) $display("FAIL reset_gnt: got %b expected 0", if_gnt_o);
    else n_pass++;
    n_total++;
    if (dut.state_r !== IDLE) $display("FAIL reset_state: got %0d expected IDLE", dut.state_r);
    else n_pass++;
    if_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int cyc;
    @(posedge clk); #1;
    if_addr_i = 32'h0000_0100;
    if_req_i  = 1'b1;
    exp_mem_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 4'hF});
    exp_if_q.push_back(32'h0050_0093);
    #1;
    n_total++;
    if (if_gnt_o !== 1'b1) $display("FAIL fetch_gnt: got %b expected 1", if_gnt_o);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if ({if_gnt_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0000_0100})
      $display("FAIL fetch_mem_req: got gnt=%b req=%b addr=%h expected 0/1/00000100",
               if_gnt_o, mem_req_o, mem_addr_o);
    else n_pass++;
    cyc = 1;
    while (!if_valid_o && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
    end
    n_total++;
    if (cyc != 4) $display("FAIL fetch_valid_latency: got %0d cycles expected 4", cyc);
    else n_pass++;
    n_total++;
    if ({if_rdata_o, mem_req_o} !== {32'h0050_0093, 1'b0})
      $display("FAIL fetch_complete: got rdata=%h req=%b expected 00500093/0", if_rdata_o, mem_req_o);
    else n_pass++;
    if_req_i = 1'b0;
    @(posedge clk); #2;
    n_total++;
    if (if_valid_o !== 1'b0) $display("FAIL fetch_valid_pulse: got %b expected 0", if_valid_o);
    else n_pass++;
  endtask

  task automatic test_priority();
    int cyc;
    @(posedge clk); #1;
    if_addr_i = 32'h0000_0200;
    if_req_i  = 1'b1;
    d_addr_i  = 32'h0000_2000;
    d_wdata_i = 32'h1111_2222;
    d_be_i    = 4'hF;
    d_read_i  = 1'b1;
    exp_mem_q.push_back('{32'h0000_2000, 1'b0, 32'h1111_2222, 4'hF});
    exp_mem_q.push_back('{32'h0000_0200, 1'b0, 32'h0, 4'hF});
    exp_d_q.push_back(mem_data(32'h0000_2000));
    exp_if_q.push_back(mem_data(32'h0000_0200));
    #1;
    n_total++;
    if (if_gnt_o !== 1'b0) $display("FAIL prio_data_wins: got if_gnt %b expected 0", if_gnt_o);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if ({mem_we_o, mem_addr_o} !== {1'b0, 32'h0000_2000})
      $display("FAIL prio_load_fields: got we=%b addr=%h expected 0/00002000", mem_we_o, mem_addr_o);
    else n_pass++;
    cyc = 0;
    while (!d_valid_o && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
    end
    n_total++;
    if (!d_valid_o) $display("FAIL prio_load_timeout: got no d_valid expected one within 20 cycles");
    else n_pass++;
    d_read_i = 1'b0;
    n_total++;
    if (if_gnt_o !== 1'b0) $display("FAIL prio_no_gnt_in_valid: got %b expected 0", if_gnt_o);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if (if_gnt_o !== 1'b1) $display("FAIL prio_fetch_after_idle: got %b expected 1", if_gnt_o);
    else n_pass++;
    cyc = 0;
    while (!if_valid_o && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
    end
    if_req_i = 1'b0;
  endtask

  task automatic test_starve();
    int nd;
    int gnt_at;
    bit done;
    for (int k = 0; k < 4; k++) begin
      exp_mem_q.push_back('{32'h0000_3000 + 32'(4 * k), 1'b0, 32'h0, 4'hF});
      exp_d_q.push_back(mem_data(32'h0000_3000 + 32'(4 * k)));
    end
    exp_mem_q.push_back('{32'h0000_0400, 1'b0, 32'h0, 4'hF});
    exp_if_q.push_back(mem_data(32'h0000_0400));
    exp_mem_q.push_back('{32'h0000_3010, 1'b0, 32'h0, 4'hF});
    exp_d_q.push_back(mem_data(32'h0000_3010));
    @(posedge clk); #1;
    if_addr_i = 32'h0000_0400;
    if_req_i  = 1'b1;
    d_addr_i  = 32'h0000_3000;
    d_wdata_i = 32'h0;
    d_be_i    = 4'hF;
    d_read_i  = 1'b1;
    nd = 0;
    gnt_at = -1;
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge clk); #2;
      if (if_gnt_o && gnt_at < 0) begin
        gnt_at = nd;
        n_total++;
        if (dut.starve_r !== 3'd4) $display("FAIL starve_at_limit: got %0d expected 4", dut.starve_r);
        else n_pass++;
      end
      if (if_valid_o) begin
        if_req_i = 1'b0;
        n_total++;
        if (dut.starve_r !== 3'd0) $display("FAIL starve_cleared: got %0d expected 0", dut.starve_r);
        else n_pass++;
      end
      if (d_valid_o) begin
        nd++;
        if (nd == 5) begin
          d_read_i = 1'b0;
          done = 1'b1;
        end else begin
          d_addr_i = 32'h0000_3000 + 32'(4 * nd);
        end
      end
    end
    n_total++;
    if (gnt_at != 4) $display("FAIL starve_data_grants: got %0d expected 4", gnt_at);
    else n_pass++;
    n_total++;
    if (!done) $display("FAIL starve_timeout: got %0d data completions expected 5", nd);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [31:0] t_addr [2] = '{32'h0000_4000, 32'h0000_4010};
    logic [31:0] t_wdata[2] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    logic [3:0]  t_be   [2] = '{4'b0011, 4'b1100};
    bit          t_both [2] = '{1'b0, 1'b1};
    int          t_lat  [2] = '{3, 1};
    logic [31:0] prev;
    int hold, bad, nv;
    prev = mem_data(32'h0000_3010);
    for (int i = 0; i < 2; i++) begin
      mem_lat = t_lat[i];
      @(posedge clk); #1;
      d_addr_i  = t_addr[i];
      d_wdata_i = t_wdata[i];
      d_be_i    = t_be[i];
      d_write_i = 1'b1;
      d_read_i  = t_both[i];
      exp_mem_q.push_back('{t_addr[i], 1'b1, t_wdata[i], t_be[i]});
      exp_d_q.push_back(prev);
      hold = 0;
      bad = 0;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #2;
        if (mem_req_o) begin
          hold++;
          if ({mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o} !== {t_addr[i], 1'b1, t_wdata[i], t_be[i]})
            bad++;
        end
        if (d_valid_o) begin
          nv++;
          d_write_i = 1'b0;
          d_read_i  = 1'b0;
        end
      end
      n_total++;
      if (hold != t_lat[i] + 1 || bad != 0)
        $display("FAIL store_hold[%0d]: got %0d cycles, %0d unstable expected %0d cycles, 0 unstable",
                 i, hold, bad, t_lat[i] + 1);
      else n_pass++;
      n_total++;
      if (nv != 1) $display("FAIL store_valid_pulses[%0d]: got %0d expected 1", i, nv);
      else n_pass++;
      n_total++;
      if (d_rdata_o !== prev) $display("FAIL store_rdata_kept[%0d]: got %h expected %h", i, d_rdata_o, prev);
      else n_pass++;
    end
    mem_lat = 2;
  endtask

  task automatic test_reset_mid();
    int dv;
    mem_auto  = 1'b0;
    mem_ack_i = 1'b0;
    @(posedge clk); #1;
    d_addr_i  = 32'h0000_5000;
    d_wdata_i = 32'h0;
    d_be_i    = 4'hF;
    d_read_i  = 1'b1;
    exp_mem_q.push_back('{32'h0000_5000, 1'b0, 32'h0, 4'hF});
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if ({mem_req_o, dut.state_r} !== {1'b1, BUSY_D})
      $display("FAIL rstmid_busy: got req=%b state=%0d expected 1/BUSY_D", mem_req_o, dut.state_r);
    else n_pass++;
    rst = 1'b1;
    d_read_i = 1'b0;
    #1;
    n_total++;
    if ({mem_req_o, mem_addr_o} !== 33'd0)
      $display("FAIL rstmid_async: got req=%b addr=%h expected 0/00000000", mem_req_o, mem_addr_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    dv = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      if (d_valid_o) dv++;
    end
    n_total++;
    if (dv != 0 || dut.state_r !== IDLE || mem_req_o !== 1'b0 || d_rdata_o !== 32'h0)
      $display("FAIL rstmid_stale_ack: got valids=%0d state=%0d req=%b rdata=%h expected 0/IDLE/0/00000000",
               dv, dut.state_r, mem_req_o, d_rdata_o);
    else n_pass++;
    wait_cnt = 0;
    mem_auto = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    d_read_i    = 1'b0;
    d_write_i   = 1'b0;
    d_addr_i    = 32'h0;
    d_wdata_i   = 32'h0;
    d_be_i      = 4'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    repeat (2) @(posedge clk);
    n_total++;
    if (exp_mem_q.size() + exp_if_q.size() + exp_d_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d entries left expected 0/0/0",
               exp_mem_q.size(), exp_if_q.size(), exp_d_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
